// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared cache definitions: valid-array geometry, the valid-clear controller
// state encoding and a small saturating-increment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  // Controller states; the encoding is visible to other cache blocks.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // 8-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/valid_clear_ctrl_if.sv
// ---------------------------------------------------------------------------
// valid_clear_ctrl_if
// Bundles the cache-side request/status signals and the valid-array port of
// the valid-clear controller.
//   master : cache wrapper side (drives requests and array read data)
//   slave  : controller side (drives array address/strobe/data and status)
// Signals:
//   flush_req, req_addr, req_write, req_wdata : cache requests
//   mem_addr, mem_write, mem_din, mem_dout    : valid-array port
//   valid_out, ready, clear_done, clear_cnt   : status back to the cache
// ---------------------------------------------------------------------------
interface valid_clear_ctrl_if #(
  parameter int ADDR_W = cache_pkg::ADDR_W
);

  logic              flush_req;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic              req_wdata;
  logic              mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic              mem_din;
  logic              valid_out;
  logic              ready;
  logic              clear_done;
  logic [7:0]        clear_cnt;

  modport master (
    output flush_req, req_addr, req_write, req_wdata, mem_dout,
    input  mem_addr, mem_write, mem_din, valid_out, ready, clear_done, clear_cnt
  );

  modport slave (
    input  flush_req, req_addr, req_write, req_wdata, mem_dout,
    output mem_addr, mem_write, mem_din, valid_out, ready, clear_done, clear_cnt
  );

endinterface

// File: rtl/valid_clear_ctrl.sv
// ---------------------------------------------------------------------------
// valid_clear_ctrl
// Owns the valid-bit array of a cache: after reset or a flush it walks every
// entry writing 0 (CLEAR), then passes cache accesses straight through to the
// array (READY).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : valid_clear_ctrl_if.slave
//          - in  : flush_req, req_addr, req_write, req_wdata, mem_dout
//          - out : mem_addr, mem_write, mem_din (array port)
//                  valid_out (qualified valid), ready, clear_done (1-cycle
//                  pulse on walk completion), clear_cnt (saturating walks)
// ---------------------------------------------------------------------------
module valid_clear_ctrl #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DEPTH  = cache_pkg::DEPTH
) (
  input logic               clk,
  input logic               rst,
  valid_clear_ctrl_if.slave bus
);

  import cache_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_r;
  logic [ADDR_W-1:0] walk_r;
  logic              ready_r;
  logic              clear_done_r;
  logic [7:0]        clear_cnt_r;

  logic [ADDR_W-1:0] mem_addr_s;
  logic              mem_write_s;
  logic              mem_din_s;
  logic              valid_out_s;

  // State machine, walk counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= CLEAR;
      walk_r       <= '0;
      ready_r      <= 1'b0;
      clear_done_r <= 1'b0;
      clear_cnt_r  <= 8'd0;
    end else begin
      case (state_r)
        CLEAR: begin
          // flush_req is deliberately not looked at here: a flush during a
          // walk must not restart it.
          if (walk_r == LAST_ADDR) begin
            state_r      <= READY;
            walk_r       <= '0;
            ready_r      <= 1'b1;
            clear_done_r <= 1'b1;
            clear_cnt_r  <= sat_inc8(clear_cnt_r);
          end else begin
            walk_r       <= walk_r + ADDR_ONE;
            ready_r      <= 1'b0;
            clear_done_r <= 1'b0;
          end
        end
        READY: begin
          clear_done_r <= 1'b0;
          if (bus.flush_req) begin
            state_r <= CLEAR;
            walk_r  <= '0;
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= CLEAR;
          walk_r       <= '0;
          ready_r      <= 1'b0;
          clear_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Array port mux: walk writes in CLEAR, cache pass-through in READY.
  // rst gates the strobe directly so nothing is written before the
  // synchronous reset has taken effect.
  always_comb begin
    mem_addr_s  = walk_r;
    mem_write_s = 1'b0;
    mem_din_s   = 1'b0;
    valid_out_s = 1'b0;
    if (rst) begin
      mem_write_s = 1'b0;
      valid_out_s = 1'b0;
    end else if (state_r == READY) begin
      mem_addr_s  = bus.req_addr;
      mem_write_s = bus.req_write;
      mem_din_s   = bus.req_wdata;
      valid_out_s = bus.mem_dout;
    end else begin
      // req_write is dropped while clearing.
      mem_addr_s  = walk_r;
      mem_write_s = 1'b1;
      mem_din_s   = 1'b0;
      valid_out_s = 1'b0;
    end
  end

  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.mem_din    = mem_din_s;
  assign bus.valid_out  = valid_out_s;
  assign bus.ready      = ready_r;
  assign bus.clear_done = clear_done_r;
  assign bus.clear_cnt  = clear_cnt_r;

endmodule

// File: tb/tb_valid_clear_ctrl.sv
// ---------------------------------------------------------------------------
// tb_valid_clear_ctrl
// Directed bench for valid_clear_ctrl with a behavioural valid array
// (combinational read, clocked write) hooked to the array port.
// ---------------------------------------------------------------------------
module tb_valid_clear_ctrl;

  import cache_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  integer pass_cnt  = 0;
  integer total_cnt = 0;
  integer bad_wr    = 0;
  logic   vmem [0:DEPTH-1];

  valid_clear_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  valid_clear_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // valid array model
  assign bus.mem_dout = vmem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_write) vmem[bus.mem_addr] <= bus.mem_din;
  end

  // any write of a 1 while the array is not usable is a leaked cache write
  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_din && !bus.ready) bad_wr <= bad_wr + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (bus.ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ready); else pass_cnt++;
    total_cnt++; if (bus.clear_done !== 1'b0) $display("FAIL rst_clear_done: got %b want 0", bus.clear_done); else pass_cnt++;
    total_cnt++; if (bus.clear_cnt !== 8'd0) $display("FAIL rst_clear_cnt: got %0d want 0", bus.clear_cnt); else pass_cnt++;
    total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); else pass_cnt++;
    total_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL rst_valid_out: got %b want 0", bus.valid_out); else pass_cnt++;
  endtask

  task automatic test_walk();
    int err = 0;
    int ones = 0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.mem_write !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.mem_din !== 1'b0 ||
          bus.ready !== 1'b0 || bus.valid_out !== 1'b0) err++;
      tick();
    end
    total_cnt++; if (err != 0) $display("FAIL walk_seq: got %0d bad cycles want 0", err); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL walk_ready: got %b want 1", bus.ready); else pass_cnt++;
    total_cnt++; if (bus.clear_done !== 1'b1) $display("FAIL walk_done: got %b want 1", bus.clear_done); else pass_cnt++;
    total_cnt++; if (bus.clear_cnt !== 8'd1) $display("FAIL walk_cnt: got %0d want 1", bus.clear_cnt); else pass_cnt++;
    for (int j = 0; j < DEPTH; j++) if (vmem[j] !== 1'b0) ones++;
    total_cnt++; if (ones != 0) $display("FAIL walk_cleared: got %0d set entries want 0", ones); else pass_cnt++;
    tick();
    total_cnt++; if (bus.clear_done !== 1'b0) $display("FAIL done_pulse: got %b want 0", bus.clear_done); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL ready_hold: got %b want 1", bus.ready); else pass_cnt++;
  endtask

  task automatic test_write_read();
    bus.req_addr  = 8'h3C;
    bus.req_write = 1'b1;
    bus.req_wdata = 1'b1;
    #1;
    total_cnt++; if (bus.mem_write !== 1'b1) $display("FAIL pass_write: got %b want 1", bus.mem_write); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 8'h3C) $display("FAIL pass_addr: got %h want 3c", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_din !== 1'b1) $display("FAIL pass_din: got %b want 1", bus.mem_din); else pass_cnt++;
    tick();
    bus.req_write = 1'b0;
    bus.req_wdata = 1'b0;
    #1;
    total_cnt++; if (bus.valid_out !== 1'b1) $display("FAIL read_3c: got %b want 1", bus.valid_out); else pass_cnt++;
    bus.req_addr = 8'h3D;
    #1;
    total_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL read_3d: got %b want 0", bus.valid_out); else pass_cnt++;
  endtask

  task automatic test_flush_with_write();
    bus.req_addr  = 8'h10;
    bus.req_write = 1'b1;
    bus.req_wdata = 1'b1;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    bus.req_write = 1'b0;
    bus.req_wdata = 1'b0;
    #1;
    total_cnt++; if (bus.ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.ready); else pass_cnt++;
    total_cnt++; if (vmem[8'h10] !== 1'b1) $display("FAIL flush_wr_done: got %b want 1", vmem[8'h10]); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 8'h00) $display("FAIL flush_addr0: got %h want 00", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.valid_out); else pass_cnt++;
    repeat (DEPTH) tick();
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL flush_end_ready: got %b want 1", bus.ready); else pass_cnt++;
    total_cnt++; if (bus.clear_done !== 1'b1) $display("FAIL flush_end_done: got %b want 1", bus.clear_done); else pass_cnt++;
    total_cnt++; if (bus.clear_cnt !== 8'd2) $display("FAIL flush_end_cnt: got %0d want 2", bus.clear_cnt); else pass_cnt++;
    bus.req_addr = 8'h10;
    #1;
    total_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL flush_read_10: got %b want 0", bus.valid_out); else pass_cnt++;
  endtask

  task automatic test_flush_during_clear();
    int pulses = 0;
    int first  = 0;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (100) tick();
    total_cnt++; if (bus.mem_addr !== 8'd100) $display("FAIL fdc_addr100: got %0d want 100", bus.mem_addr); else pass_cnt++;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    #1;
    total_cnt++; if (bus.mem_addr !== 8'd101) $display("FAIL fdc_no_restart: got %0d want 101", bus.mem_addr); else pass_cnt++;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (bus.clear_done === 1'b1) pulses++;
      if (bus.ready === 1'b1 && first == 0) first = k;
    end
    total_cnt++; if (first != 155) $display("FAIL fdc_ready_cycle: got %0d want 155", first); else pass_cnt++;
    total_cnt++; if (pulses != 1) $display("FAIL fdc_pulses: got %0d want 1", pulses); else pass_cnt++;
    total_cnt++; if (bus.clear_cnt !== 8'd3) $display("FAIL fdc_cnt: got %0d want 3", bus.clear_cnt); else pass_cnt++;
  endtask

  task automatic test_write_during_clear();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (3) tick();
    bus.req_addr  = 8'h05;
    bus.req_write = 1'b1;
    bus.req_wdata = 1'b1;
    #1;
    total_cnt++; if (bus.mem_addr !== 8'h03) $display("FAIL wdc_addr: got %h want 03", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_din !== 1'b0) $display("FAIL wdc_din: got %b want 0", bus.mem_din); else pass_cnt++;
    total_cnt++; if (bus.mem_write !== 1'b1) $display("FAIL wdc_write: got %b want 1", bus.mem_write); else pass_cnt++;
    tick();
    bus.req_write = 1'b0;
    bus.req_wdata = 1'b0;
    repeat (DEPTH - 4) tick();
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL wdc_ready: got %b want 1", bus.ready); else pass_cnt++;
    total_cnt++; if (bus.clear_cnt !== 8'd4) $display("FAIL wdc_cnt: got %0d want 4", bus.clear_cnt); else pass_cnt++;
    total_cnt++; if (bad_wr != 0) $display("FAIL wdc_leaked_writes: got %0d want 0", bad_wr); else pass_cnt++;
    bus.req_addr = 8'h05;
    #1;
    total_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL wdc_read_05: got %b want 0", bus.valid_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid_walk();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (200) tick();
    total_cnt++; if (bus.mem_addr !== 8'd200) $display("FAIL rmw_addr200: got %0d want 200", bus.mem_addr); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL rmw_rst_write: got %b want 0", bus.mem_write); else pass_cnt++;
    tick();
    total_cnt++; if (bus.clear_cnt !== 8'd0) $display("FAIL rmw_cnt_clr: got %0d want 0", bus.clear_cnt); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b0) $display("FAIL rmw_ready: got %b want 0", bus.ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.mem_addr !== 8'd0 || bus.mem_write !== 1'b1) $display("FAIL rmw_restart: got addr %0d wr %b want addr 0 wr 1", bus.mem_addr, bus.mem_write); else pass_cnt++;
    repeat (DEPTH - 1) tick();
    total_cnt++; if (bus.mem_addr !== 8'd255 || bus.clear_cnt !== 8'd0) $display("FAIL rmw_last: got addr %0d cnt %0d want addr 255 cnt 0", bus.mem_addr, bus.clear_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (bus.ready !== 1'b1 || bus.clear_done !== 1'b1) $display("FAIL rmw_done: got ready %b done %b want 1 1", bus.ready, bus.clear_done); else pass_cnt++;
    total_cnt++; if (bus.clear_cnt !== 8'd1) $display("FAIL rmw_cnt: got %0d want 1", bus.clear_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 256; n++) begin
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      repeat (DEPTH) tick();
      if (n == 253) begin
        total_cnt++; if (bus.clear_cnt !== 8'd255) $display("FAIL sat_reach: got %0d want 255", bus.clear_cnt); else pass_cnt++;
      end
    end
    total_cnt++; if (bus.clear_cnt !== 8'd255) $display("FAIL sat_hold: got %0d want 255", bus.clear_cnt); else pass_cnt++;
    total_cnt++; if (bus.clear_done !== 1'b1) $display("FAIL sat_done: got %b want 1", bus.clear_done); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL sat_ready: got %b want 1", bus.ready); else pass_cnt++;
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) vmem[j] <= 1'b1;
    rst           = 1'b1;
    bus.flush_req = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_write = 1'b0;
    bus.req_wdata = 1'b0;
    test_reset();
    test_walk();
    test_write_read();
    test_flush_with_write();
    test_flush_during_clear();
    test_write_during_clear();
    test_reset_mid_walk();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
